// File: rtl/params_pkg.sv
// Shared CPU memory-system parameters and types: line geometry, access sizes,
// and the state/owner encodings used by the memory-port arbiter.
package params_pkg;

  localparam int ADDR_WIDTH       = 32;
  localparam int CACHE_LINE_BYTES = 16;

  typedef enum logic [1:0] {
    ACC_BYTE = 2'd0,
    ACC_HALF = 2'd1,
    ACC_WORD = 2'd2,
    ACC_LINE = 2'd3
  } access_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    IC = 1'b0,
    DC = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single cache-line memory port between icache and dcache, one
// transaction outstanding. Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties.
module mem_arbiter
  import params_pkg::*;
#(
  parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
  parameter int LINE_WIDTH = params_pkg::CACHE_LINE_BYTES * 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  ic_rd_req_i,
  input  logic [ADDR_WIDTH-1:0] ic_addr_i,
  input  access_size_t          ic_access_size_i,
  output logic                  ic_rsp_valid_o,
  output logic [LINE_WIDTH-1:0] ic_rsp_data_o,

  input  logic                  dc_rd_req_i,
  input  logic                  dc_wr_req_i,
  input  logic [ADDR_WIDTH-1:0] dc_addr_i,
  input  logic [LINE_WIDTH-1:0] dc_wr_data_i,
  input  access_size_t          dc_access_size_i,
  output logic                  dc_rsp_valid_o,
  output logic [LINE_WIDTH-1:0] dc_rsp_data_o,
  output logic                  dc_wr_done_o,

  output logic                  mem_rd_req_valid_o,
  output logic                  mem_wr_req_valid_o,
  output logic                  mem_req_is_instr_o,
  output logic [ADDR_WIDTH-1:0] mem_req_address_o,
  output logic [LINE_WIDTH-1:0] mem_wr_data_o,
  output access_size_t          mem_req_access_size_o,

  input  logic                  mem_data_valid_i,
  input  logic [LINE_WIDTH-1:0] mem_data_i,
  input  logic                  mem_write_done_i
);

  arb_state_t            state_q, state_d;
  arb_owner_t            owner_q, owner_d;
  logic                  is_wr_q, is_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  access_size_t          size_q, size_d;
  logic [LINE_WIDTH-1:0] ic_data_q, ic_data_d;
  logic [LINE_WIDTH-1:0] dc_data_q, dc_data_d;

  logic req_any;
  logic dc_req;
  logic grant_ic;

  assign dc_req  = dc_rd_req_i | dc_wr_req_i;
  assign req_any = ic_rd_req_i | dc_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_owner_t last_q, last_d;

  // On a tie the icache wins only if the dcache was granted last.
  always_comb begin
    grant_ic = ic_rd_req_i & (~dc_req | (last_q == DC));
  end

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && req_any) begin
      last_d = grant_ic ? IC : DC;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_q <= DC;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    grant_ic = ic_rd_req_i & ~dc_req;
  end
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    ic_data_d = ic_data_q;
    dc_data_d = dc_data_q;

    case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d = BUSY;
          owner_d = grant_ic ? IC : DC;
          // A simultaneous dcache read and write resolves to the write.
          is_wr_d = ~grant_ic & dc_wr_req_i;
          addr_d  = grant_ic ? ic_addr_i : dc_addr_i;
          wdata_d = grant_ic ? '0 : dc_wr_data_i;
          size_d  = grant_ic ? ic_access_size_i : dc_access_size_i;
        end
      end
      BUSY: begin
        if (is_wr_q) begin
          if (mem_write_done_i) begin
            state_d = RESP;
          end
        end else if (mem_data_valid_i) begin
          state_d = RESP;
          if (owner_q == IC) begin
            ic_data_d = mem_data_i;
          end else begin
            dc_data_d = mem_data_i;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      owner_q   <= DC;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= ACC_BYTE;
      ic_data_q <= '0;
      dc_data_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      ic_data_q <= ic_data_d;
      dc_data_q <= dc_data_d;
    end
  end

  logic busy;
  logic resp;

  assign busy = (state_q == BUSY);
  assign resp = (state_q == RESP);

  // Memory-side outputs are decoded from registers only and are quiet outside BUSY.
  assign mem_rd_req_valid_o    = busy & ~is_wr_q;
  assign mem_wr_req_valid_o    = busy & is_wr_q;
  assign mem_req_is_instr_o    = busy & (owner_q == IC);
  assign mem_req_address_o     = busy ? addr_q : '0;
  assign mem_wr_data_o         = busy ? wdata_q : '0;
  assign mem_req_access_size_o = busy ? size_q : ACC_BYTE;

  assign ic_rsp_valid_o = resp & (owner_q == IC);
  assign dc_rsp_valid_o = resp & (owner_q == DC) & ~is_wr_q;
  assign dc_wr_done_o   = resp & (owner_q == DC) & is_wr_q;
  assign ic_rsp_data_o  = ic_data_q;
  assign dc_rsp_data_o  = dc_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, tie/reset sequences and a
// randomized phase checked against a transaction-level arbitration model.
module tb_mem_arbiter;
  import params_pkg::*;

  localparam int AW = ADDR_WIDTH;
  localparam int LW = CACHE_LINE_BYTES * 8;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          ic_rd_req_i;
  logic [AW-1:0] ic_addr_i;
  access_size_t  ic_access_size_i;
  logic          ic_rsp_valid_o;
  logic [LW-1:0] ic_rsp_data_o;
  logic          dc_rd_req_i;
  logic          dc_wr_req_i;
  logic [AW-1:0] dc_addr_i;
  logic [LW-1:0] dc_wr_data_i;
  access_size_t  dc_access_size_i;
  logic          dc_rsp_valid_o;
  logic [LW-1:0] dc_rsp_data_o;
  logic          dc_wr_done_o;
  logic          mem_rd_req_valid_o;
  logic          mem_wr_req_valid_o;
  logic          mem_req_is_instr_o;
  logic [AW-1:0] mem_req_address_o;
  logic [LW-1:0] mem_wr_data_o;
  access_size_t  mem_req_access_size_o;
  logic          mem_data_valid_i;
  logic [LW-1:0] mem_data_i;
  logic          mem_write_done_i;

  mem_arbiter dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .ic_rd_req_i          (ic_rd_req_i),
    .ic_addr_i            (ic_addr_i),
    .ic_access_size_i     (ic_access_size_i),
    .ic_rsp_valid_o       (ic_rsp_valid_o),
    .ic_rsp_data_o        (ic_rsp_data_o),
    .dc_rd_req_i          (dc_rd_req_i),
    .dc_wr_req_i          (dc_wr_req_i),
    .dc_addr_i            (dc_addr_i),
    .dc_wr_data_i         (dc_wr_data_i),
    .dc_access_size_i     (dc_access_size_i),
    .dc_rsp_valid_o       (dc_rsp_valid_o),
    .dc_rsp_data_o        (dc_rsp_data_o),
    .dc_wr_done_o         (dc_wr_done_o),
    .mem_rd_req_valid_o   (mem_rd_req_valid_o),
    .mem_wr_req_valid_o   (mem_wr_req_valid_o),
    .mem_req_is_instr_o   (mem_req_is_instr_o),
    .mem_req_address_o    (mem_req_address_o),
    .mem_wr_data_o        (mem_wr_data_o),
    .mem_req_access_size_o(mem_req_access_size_o),
    .mem_data_valid_i     (mem_data_valid_i),
    .mem_data_i           (mem_data_i),
    .mem_write_done_i     (mem_write_done_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: who was granted last and what each response bus should hold.
  bit            last_dc;
  logic [LW-1:0] exp_ic_data;
  logic [LW-1:0] exp_dc_data;

  typedef struct {
    logic          ic;
    logic          dcr;
    logic          dcw;
    logic [AW-1:0] ia;
    logic [AW-1:0] da;
    logic [LW-1:0] wd;
    int            lat;
    bit            wrong;
    bit            exp_ic;
    bit            exp_wr;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One transaction from an IDLE negedge back to the next IDLE negedge.
  task automatic run_txn(input logic ic, input logic dcr, input logic dcw,
                         input logic [AW-1:0] ia, input logic [AW-1:0] da,
                         input access_size_t isz, input access_size_t dsz,
                         input logic [LW-1:0] wd, input logic [LW-1:0] rd,
                         input int lat, input bit wrong,
                         input bit exp_ic, input bit exp_wr,
                         input logic [AW-1:0] exp_addr, input string tag);
    logic [LW-1:0] pulses;
    ic_rd_req_i      = ic;
    dc_rd_req_i      = dcr;
    dc_wr_req_i      = dcw;
    ic_addr_i        = ia;
    dc_addr_i        = da;
    ic_access_size_i = isz;
    dc_access_size_i = dsz;
    dc_wr_data_i     = wd;
    @(negedge clk_i);
    chk({tag, " mem_rd"}, mem_rd_req_valid_o, !exp_wr);
    chk({tag, " mem_wr"}, mem_wr_req_valid_o, exp_wr);
    chk({tag, " is_instr"}, mem_req_is_instr_o, exp_ic);
    chk({tag, " addr"}, mem_req_address_o, exp_addr);
    chk({tag, " size"}, mem_req_access_size_o, exp_ic ? isz : dsz);
    if (exp_wr) chk({tag, " wdata"}, mem_wr_data_o, wd);
    // Requester inputs wander during BUSY; the memory port must not follow them.
    ic_addr_i    = ~ia;
    dc_addr_i    = ~da;
    dc_wr_data_i = ~wd;
    for (int i = 0; i < lat - 1; i++) begin
      if (wrong && i == 0) begin
        if (exp_wr) begin
          mem_data_valid_i = 1'b1;
          mem_data_i       = rand_line();
        end else begin
          mem_write_done_i = 1'b1;
        end
      end
      @(negedge clk_i);
      mem_data_valid_i = 1'b0;
      mem_write_done_i = 1'b0;
      chk({tag, " held"},
          {mem_rd_req_valid_o, mem_wr_req_valid_o, mem_req_address_o,
           ic_rsp_valid_o, dc_rsp_valid_o, dc_wr_done_o},
          {!exp_wr, exp_wr, exp_addr, 3'b000});
    end
    if (exp_wr) begin
      mem_write_done_i = 1'b1;
    end else begin
      mem_data_valid_i = 1'b1;
      mem_data_i       = rd;
    end
    @(negedge clk_i);
    mem_data_valid_i = 1'b0;
    mem_write_done_i = 1'b0;
    mem_data_i       = rand_line();
    pulses = {ic_rsp_valid_o, dc_rsp_valid_o, dc_wr_done_o};
    chk({tag, " pulses"}, pulses, {exp_ic, !exp_ic && !exp_wr, exp_wr});
    chk({tag, " resp_mem_low"}, {mem_rd_req_valid_o, mem_wr_req_valid_o}, 2'b00);
    if (!exp_wr) begin
      if (exp_ic) exp_ic_data = rd;
      else        exp_dc_data = rd;
      chk({tag, " rdata"}, exp_ic ? ic_rsp_data_o : dc_rsp_data_o, rd);
    end
    ic_addr_i    = ia;
    dc_addr_i    = da;
    dc_wr_data_i = wd;
    if (exp_ic) begin
      ic_rd_req_i = 1'b0;
    end else begin
      dc_rd_req_i = 1'b0;
      dc_wr_req_i = 1'b0;
    end
    last_dc = !exp_ic;
    @(negedge clk_i);
    chk({tag, " idle"},
        {mem_rd_req_valid_o, mem_wr_req_valid_o, ic_rsp_valid_o, dc_rsp_valid_o, dc_wr_done_o},
        5'b0);
    chk({tag, " ic_hold"}, ic_rsp_data_o, exp_ic_data);
    chk({tag, " dc_hold"}, dc_rsp_data_o, exp_dc_data);
    $display("txn %s: owner=%s op=%s addr=%0h lat=%0d", tag, exp_ic ? "IC" : "DC",
             exp_wr ? "WR" : "RD", exp_addr, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          r_ic, r_dcr, r_dcw, win_ic, r_wr;
    logic [AW-1:0] r_ia, r_da;
    logic [LW-1:0] r_wd;
    access_size_t  r_isz, r_dsz;
    int            r_lat;

    rst_i            = 1'b0;
    ic_rd_req_i      = 1'b0;
    ic_addr_i        = '0;
    ic_access_size_i = ACC_LINE;
    dc_rd_req_i      = 1'b0;
    dc_wr_req_i      = 1'b0;
    dc_addr_i        = '0;
    dc_wr_data_i     = '0;
    dc_access_size_i = ACC_WORD;
    mem_data_valid_i = 1'b0;
    mem_data_i       = '0;
    mem_write_done_i = 1'b0;
    last_dc          = 1'b1;
    exp_ic_data      = '0;
    exp_dc_data      = '0;

    repeat (2) @(negedge clk_i);
    chk("reset outputs",
        {mem_rd_req_valid_o, mem_wr_req_valid_o, mem_req_is_instr_o, mem_req_address_o,
         ic_rsp_valid_o, dc_rsp_valid_o, dc_wr_done_o},
        '0);
    chk("reset ic_data", ic_rsp_data_o, '0);
    chk("reset dc_data", dc_rsp_data_o, '0);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("post-reset idle", {mem_rd_req_valid_o, mem_wr_req_valid_o}, 2'b00);

    // Ties straight after reset: round-robin gives IC,DC,IC,DC, fixed gives DC,IC,DC,IC.
    for (int k = 0; k < 2; k++) begin
      run_txn(1'b1, 1'b1, 1'b0, 32'h0, 32'h80, ACC_LINE, ACC_LINE, '0, rand_line(),
              2, 1'b0, RR, 1'b0, RR ? 32'h0 : 32'h80, "tie_first");
      run_txn(ic_rd_req_i, dc_rd_req_i, 1'b0, 32'h0, 32'h80, ACC_LINE, ACC_LINE, '0,
              rand_line(), 2, 1'b0, !RR, 1'b0, RR ? 32'h80 : 32'h0, "tie_second");
    end

    vecs[0] = '{1, 0, 0, 32'h40,  32'h0,   '0,                   3, 0, 1, 0, 32'h40};
    vecs[1] = '{0, 0, 1, 32'h0,   32'h100, 128'hDEADBEEF,        2, 0, 0, 1, 32'h100};
    vecs[2] = '{0, 1, 0, 32'h0,   32'h10,  '0,                   1, 0, 0, 0, 32'h10};
    vecs[3] = '{0, 1, 0, 32'h0,   32'h20,  '0,                   2, 0, 0, 0, 32'h20};
    vecs[4] = '{0, 1, 1, 32'h0,   32'h200, 128'h1234_5678_9ABC,  4, 1, 0, 1, 32'h200};
    vecs[5] = '{1, 0, 0, 32'h80,  32'h0,   '0,                   4, 1, 1, 0, 32'h80};
    for (int v = 0; v < 6; v++) begin
      run_txn(vecs[v].ic, vecs[v].dcr, vecs[v].dcw, vecs[v].ia, vecs[v].da, ACC_LINE,
              ACC_WORD, vecs[v].wd, rand_line(), vecs[v].lat, vecs[v].wrong,
              vecs[v].exp_ic, vecs[v].exp_wr, vecs[v].exp_addr, $sformatf("vec%0d", v));
    end

    // Reset one cycle after a grant: everything drops at once and no pulse follows.
    dc_rd_req_i = 1'b1;
    dc_addr_i   = 32'h300;
    @(negedge clk_i);
    chk("pre-reset busy", mem_rd_req_valid_o, 1'b1);
    rst_i            = 1'b0;
    dc_rd_req_i      = 1'b0;
    mem_data_valid_i = 1'b1;
    mem_data_i       = rand_line();
    #1;
    chk("async reset outputs",
        {mem_rd_req_valid_o, mem_wr_req_valid_o, mem_req_is_instr_o, mem_req_address_o,
         ic_rsp_valid_o, dc_rsp_valid_o, dc_wr_done_o, ic_rsp_data_o[31:0], dc_rsp_data_o[31:0]},
        '0);
    @(negedge clk_i);
    rst_i            = 1'b1;
    mem_data_valid_i = 1'b0;
    exp_ic_data      = '0;
    exp_dc_data      = '0;
    last_dc          = 1'b1;
    for (int c = 0; c < 2; c++) begin
      mem_write_done_i = 1'b1;
      @(negedge clk_i);
      mem_write_done_i = 1'b0;
      chk("no pulse after reset", {ic_rsp_valid_o, dc_rsp_valid_o, dc_wr_done_o}, 3'b000);
    end
    run_txn(1'b1, 1'b0, 1'b0, 32'h440, 32'h0, ACC_LINE, ACC_WORD, '0, rand_line(), 2, 1'b0,
            1'b1, 1'b0, 32'h440, "after_reset");

    // Randomized traffic; a losing requester keeps holding its request.
    r_ia = '0; r_da = '0; r_wd = '0; r_isz = ACC_LINE; r_dsz = ACC_WORD;
    r_ic = 1'b0; r_dcr = 1'b0; r_dcw = 1'b0;
    for (int t = 0; t < 30; t++) begin
      if (!ic_rd_req_i) begin
        r_ic  = 1'($urandom_range(0, 1));
        r_ia  = {$urandom} & ~32'hF;
        r_isz = access_size_t'($urandom_range(0, 3));
      end
      if (!dc_rd_req_i && !dc_wr_req_i) begin
        r_dcr = 1'($urandom_range(0, 1));
        r_dcw = 1'($urandom_range(0, 1));
        r_da  = {$urandom} & ~32'hF;
        r_wd  = rand_line();
        r_dsz = access_size_t'($urandom_range(0, 3));
      end
      if (!r_ic && !r_dcr && !r_dcw) r_ic = 1'b1;
      if (RR) win_ic = r_ic && (!(r_dcr || r_dcw) || last_dc);
      else    win_ic = r_ic && !(r_dcr || r_dcw);
      r_wr  = !win_ic && r_dcw;
      r_lat = $urandom_range(1, 4);
      run_txn(r_ic, r_dcr, r_dcw, r_ia, r_da, r_isz, r_dsz, r_wd, rand_line(), r_lat,
              1'($urandom_range(0, 1)), win_ic, r_wr, win_ic ? r_ia : r_da,
              $sformatf("rand%0d", t));
      r_ic  = ic_rd_req_i;
      r_dcr = dc_rd_req_i;
      r_dcw = dc_wr_req_i;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single cache-line memory port between the instruction cache and the data cache inside `cpu`. Only one transaction is outstanding at a time. The arbiter latches the winning request and holds it on the memory port until `mem` responds. It then returns the response to the owner as a one-cycle pulse. It sits between the two cache controllers and the `mem` request/response interface.

## Interface
- `ADDR_WIDTH`, default `params_pkg::ADDR_WIDTH`: address width.
- `LINE_WIDTH`, default `CACHE_LINE_BYTES*8`: width of the data bus.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-low.
- `ic_rd_req_i`  in  1  icache line read request, level-held until `ic_rsp_valid_o`.
- `ic_addr_i`  in  ADDR_WIDTH  icache request address.
- `ic_access_size_i`  in  access_size_t  icache access size.
- `ic_rsp_valid_o`  out  1  one-cycle pulse: `ic_rsp_data_o` is valid.
- `ic_rsp_data_o`  out  LINE_WIDTH  returned line.
- `dc_rd_req_i`  in  1  dcache read request, level-held until response.
- `dc_wr_req_i`  in  1  dcache write request, level-held until response.
- `dc_addr_i`  in  ADDR_WIDTH  dcache address.
- `dc_wr_data_i`  in  LINE_WIDTH  dcache write data.
- `dc_access_size_i`  in  access_size_t  dcache access size.
- `dc_rsp_valid_o`  out  1  one-cycle pulse: read data valid.
- `dc_rsp_data_o`  out  LINE_WIDTH  returned read data.
- `dc_wr_done_o`  out  1  one-cycle pulse: write completed.
- `mem_rd_req_valid_o`, `mem_wr_req_valid_o`  out  1 each  memory read/write request, held for the whole transaction.
- `mem_req_is_instr_o`  out  1  transaction owner is icache.
- `mem_req_address_o`  out  ADDR_WIDTH; `mem_wr_data_o`  out  LINE_WIDTH; `mem_req_access_size_o`  out  access_size_t.
- `mem_data_valid_i`  in  1; `mem_data_i`  in  LINE_WIDTH; `mem_write_done_i`  in  1: memory responses.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE:**
  - If any request is present, pick an owner (see Configuration).
  - Latch into registers: owner, op (write if `dc_wr_req_i`, else read), address, write data, size.
  - Go to BUSY.
  - Icache writes do not exist. If `dc_rd_req_i` and `dc_wr_req_i` are both high, the write wins.
- **BUSY:**
  - Drive the latched request: exactly one of `mem_rd_req_valid_o`/`mem_wr_req_valid_o` is 1.
  - `mem_req_is_instr_o` = (owner == IC).
  - A read completes on `mem_data_valid_i`: latch `mem_data_i`, go to RESP.
  - A write completes on `mem_write_done_i`: go to RESP.
  - A response of the wrong kind for the current op is ignored.
- **RESP:**
  - Pulse exactly one of `ic_rsp_valid_o` / `dc_rsp_valid_o` / `dc_wr_done_o`, with the latched data.
  - Memory request outputs are 0.
  - Go to IDLE.
  - RESP doubles as the turnaround cycle in which the owner drops its request.
- Requests that arrive while in BUSY or RESP are not sampled. They wait, because requesters hold them.
- Requester inputs may change during BUSY without affecting the memory port, since all memory outputs come from registers.

## Timing
- Reset (async assert): state=IDLE, all outputs 0, data/address registers 0, last-grant = DC.
- Request high in IDLE at cycle t → memory request high at t+1.
- Memory response at cycle u → owner response pulse at u+1 → IDLE at u+2.
- Total overhead is 2 cycles plus memory latency. Back-to-back grants are separated by at least one cycle with memory request low.
- The memory request stays asserted continuously from BUSY entry until the response cycle inclusive, and deasserts in RESP.
- Response pulses last exactly 1 cycle. Response data holds its value until the next RESP.
- Reset mid-transaction:
  - Abandons the transaction; no response pulse is issued.
  - `mem` shares `rst_i`.
- A memory response received in IDLE or RESP is ignored.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: on a tie in IDLE, the grant goes to the requester not granted last. Last-grant updates on every grant; after reset the first tie goes to IC.
- Undefined: fixed priority, dcache wins every tie, and the last-grant register is not built.
- Single-requester behaviour is identical in both builds.

## Structure
- Add to `params_pkg`:
  - `arb_state_t` (IDLE/BUSY/RESP).
  - `arb_owner_t` (IC/DC).
- Reuse `access_size_t`, `ADDR_WIDTH`, `CACHE_LINE_BYTES` from `params_pkg`.
- Single module, no sub-module. The priority pick is a small always_comb inside the block.

## Test plan
- **Icache read:** `ic_rd_req_i`=1, addr 0x40, memory returns data 3 cycles after its request → `mem_req_is_instr_o`=1, addr 0x40 one cycle after request; `ic_rsp_valid_o` pulses 1 cycle after `mem_data_valid_i` with matching data; `dc_*` outputs stay 0.
- **Dcache write:** `dc_wr_req_i`=1, addr 0x100, data 0xDEADBEEF → `mem_wr_req_valid_o` held until `mem_write_done_i`; `dc_wr_done_o` pulses once; `dc_rsp_valid_o` stays 0.
- **Simultaneous requests:** IC reads 0x0 and DC reads 0x80 in the same cycle, repeated twice → with the macro defined, grants go IC, DC, IC, DC; without it, DC, IC, DC, IC.
- **Wrong-kind response:** `mem_write_done_i` pulsed during a read → ignored; state stays BUSY until `mem_data_valid_i`.
- **Reset mid-BUSY:** `rst_i` low one cycle after grant → all outputs 0 immediately (async); no response pulse follows; the next request is granted normally.
- **Back-to-back:** DC holds reads to 0x10 then 0x20 → at least one cycle with memory request low between the two transactions.
